// File: rtl/mem_access.sv
// mem_access -- memory-stage data-bus sequencer.
// Accepts one load/store per transaction, rejects misaligned accesses, drives
// the dbus request until the bus reports completion, then holds the raw bus
// word plus offset/size/signedness for the downstream load-extraction logic.
// Load data is never shifted here.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   flush                       discard held / in-flight result
//   in_valid/in_ready           op handshake from execute/memory register
//   in_is_load/in_is_store      op kind (neither = bypass)
//   in_addr, in_msize           byte address and access size
//   in_unsigned                 zero-extend flag for loads
//   in_wdata                    right-aligned store data
//   dreq_valid/addr/size        bus request (registered)
//   dreq_strobe, dreq_data      byte enables and lane-shifted store data
//   dresp_data_ok, dresp_data   bus completion and raw bus word
//   out_valid/out_ready         result handshake to downstream
//   out_raw, out_off            latched bus word, addr[2:0]
//   out_msize, out_unsigned     size and signedness
//   out_is_load, out_error      load flag, misaligned flag

package mem_access_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;
endpackage

module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [63:0] in_addr,
    input  msize_t      in_msize,
    input  logic        in_unsigned,
    input  logic [63:0] in_wdata,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output msize_t      dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_raw,
    output logic [2:0]  out_off,
    output msize_t      out_msize,
    output logic        out_unsigned,
    output logic        out_is_load,
    output logic        out_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_kill;
    logic [63:0] r_addr;
    msize_t      r_msize;
    logic        r_unsigned;
    logic        r_is_load;
    logic        r_error;
    logic [7:0]  r_strobe;
    logic [63:0] r_wdata_sh;
    logic [63:0] r_raw;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_bus_op;
    logic        w_store_only;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_strobe;
    logic [63:0] w_wdata_sh;

    // flush blocks acceptance in every state
    assign w_in_ready = !flush && ((r_state == S_IDLE) || (r_state == S_DONE && out_ready));
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_size_mask  = 8'h01;
        w_misaligned = 1'b0;
        unique case (in_msize)
            MSIZE1: begin w_size_mask = 8'h01; w_misaligned = 1'b0;                  end
            MSIZE2: begin w_size_mask = 8'h03; w_misaligned = in_addr[0];            end
            MSIZE4: begin w_size_mask = 8'h0F; w_misaligned = |in_addr[1:0];         end
            MSIZE8: begin w_size_mask = 8'hFF; w_misaligned = |in_addr[2:0];         end
            default: begin w_size_mask = 8'h01; w_misaligned = 1'b0;                 end
        endcase
    end

    // misalignment is checked before the bypass classification
    assign w_bus_op     = !w_misaligned && (in_is_load || in_is_store);
    assign w_store_only = in_is_store && !in_is_load;
    assign w_strobe     = w_store_only ? (w_size_mask << in_addr[2:0]) : 8'h00;
    assign w_wdata_sh   = w_store_only ? (in_wdata << {in_addr[2:0], 3'b000}) : 64'h0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_bus_op ? S_REQ : S_DONE;
            end
            S_REQ: begin
                // a flushed transaction still has to complete on the bus
                if (dresp_data_ok) w_state_nxt = (r_kill || flush) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (flush)          w_state_nxt = S_IDLE;
                else if (w_accept)  w_state_nxt = w_bus_op ? S_REQ : S_DONE;
                else if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_REQ && !dresp_data_ok) r_kill <= r_kill || flush;
            else                                    r_kill <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr     <= 64'h0;
            r_msize    <= MSIZE1;
            r_unsigned <= 1'b0;
            r_is_load  <= 1'b0;
            r_error    <= 1'b0;
            r_strobe   <= 8'h00;
            r_wdata_sh <= 64'h0;
            r_raw      <= 64'h0;
        end else if (w_accept) begin
            r_addr     <= in_addr;
            r_msize    <= in_msize;
            r_unsigned <= in_unsigned;
            r_is_load  <= in_is_load;
            r_error    <= w_misaligned;
            r_strobe   <= w_bus_op ? w_strobe : 8'h00;
            r_wdata_sh <= w_bus_op ? w_wdata_sh : 64'h0;
            r_raw      <= 64'h0;
        end else if (r_state == S_REQ && dresp_data_ok && r_is_load) begin
            r_raw      <= dresp_data;
        end
    end

    assign in_ready     = w_in_ready;
    assign dreq_valid   = (r_state == S_REQ);
    assign dreq_addr    = r_addr;
    assign dreq_size    = r_msize;
    assign dreq_strobe  = r_strobe;
    assign dreq_data    = r_wdata_sh;
    assign out_valid    = (r_state == S_DONE);
    assign out_raw      = r_raw;
    assign out_off      = r_addr[2:0];
    assign out_msize    = r_msize;
    assign out_unsigned = r_unsigned;
    assign out_is_load  = r_is_load;
    assign out_error    = r_error;

endmodule
